// File: rtl/serializador_tx_if.sv
// rtl/serializador_tx_if.sv - load handshake and serial line bundle for serializador_tx
interface serializador_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] Din;
  logic             load;
  logic             ready;
  logic             Dout_serie;
  logic             Dout_valid;
  logic             ultimo;

  modport master (
    output Din,
    output load,
    input  ready,
    input  Dout_serie,
    input  Dout_valid,
    input  ultimo
  );

  modport slave (
    input  Din,
    input  load,
    output ready,
    output Dout_serie,
    output Dout_valid,
    output ultimo
  );
endinterface

// File: rtl/serializador_tx.sv
// rtl/serializador_tx.sv - MSB-first parallel-to-serial transmitter, one bit per clock
// Optional even-parity trailer bit enabled by defining SERIALIZADOR_PARITY_EN.
module serializador_tx #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  serializador_tx_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;
  logic             serie;

`ifdef SERIALIZADOR_PARITY_EN
  logic par_q, par_d;

  // The trailer bit is the frame's final bit, so the reload window moves to it.
  assign last_bit = (state_q == PARITY);
`else
  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
`endif

  assign bus.ready      = (state_q == IDLE) || last_bit;
  assign accept         = bus.load && bus.ready;
  assign bus.Dout_valid = (state_q != IDLE);
  assign bus.ultimo     = last_bit;
  assign bus.Dout_serie = serie;

  always_comb begin
    serie = 1'b0;
    case (state_q)
      SHIFT:   serie = sr_q[WIDTH-1];
`ifdef SERIALIZADOR_PARITY_EN
      PARITY:  serie = par_q;
`endif
      default: serie = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef SERIALIZADOR_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      SHIFT: begin
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d = '0;
`ifdef SERIALIZADOR_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // A load in the final-bit cycle overrides the frame end, giving gapless frames.
    if (accept) begin
      state_d = SHIFT;
      sr_d    = bus.Din;
      cnt_d   = CW'(WIDTH - 1);
`ifdef SERIALIZADOR_PARITY_EN
      par_d   = ^bus.Din;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef SERIALIZADOR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef SERIALIZADOR_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule
